// File: rtl/ram_march_tester.sv
// Checkerboard march tester: optional full write pass, then read-compare pass with failure capture.
// Optional macro ADDR_SCRAMBLE_EN selects a rotate-right-by-one address map (alternating RAM halves).
module ram_march_tester #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned CAP_DEPTH = 4,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 write_mode,
  input  logic [DATA_W-1:0]    pattern,
  output logic [ADDR_W-1:0]    ram_address,
  output logic                 ram_wren,
  output logic [DATA_W-1:0]    ram_data,
  input  logic [DATA_W-1:0]    ram_q,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic                 cap_valid,
  output logic [ADDR_W-1:0]    cap_address,
  output logic [DATA_W-1:0]    cap_data,
  input  logic                 cap_pop,
  output logic                 cap_overflow
);
  localparam int unsigned CAP_AW = (CAP_DEPTH > 1) ? $clog2(CAP_DEPTH) : 1;
  localparam int unsigned CNT_W  = CAP_AW + 1;
  localparam int unsigned FL_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] mapped;
  logic [DATA_W-1:0] pat;
  logic [FL_W-1:0]   fl_cnt;

  logic              pipe_vld  [RD_LAT];
  logic [ADDR_W-1:0] pipe_addr [RD_LAT];

  logic [ADDR_W-1:0] cap_addr_mem [CAP_DEPTH];
  logic [DATA_W-1:0] cap_data_mem [CAP_DEPTH];
  logic [CAP_AW-1:0] cap_wp;
  logic [CAP_AW-1:0] cap_rp;
  logic [CNT_W-1:0]  cap_cnt;

  logic              accept;
  logic              mismatch;
  logic              cap_full;
  logic              pop_ok;
  logic              push_ok;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_exp;

  function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] p);
    return a[0] ? ~p : p;
  endfunction

  // Index-to-address map shared by both passes
  always_comb begin
    mapped = '0;
`ifdef ADDR_SCRAMBLE_EN
    mapped = {idx[0], idx[ADDR_W-1:1]};
`else
    mapped = idx;
`endif
  end

  assign ram_address = mapped;
  assign ram_wren    = (state == S_WRITE);
  assign ram_data    = ram_wren ? exp_word(mapped, pat) : '0;

  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  assign cmp_addr = pipe_addr[RD_LAT-1];
  assign cmp_exp  = exp_word(cmp_addr, pat);
  assign mismatch = pipe_vld[RD_LAT-1] && (ram_q != cmp_exp);

  assign cap_full    = (cap_cnt == CNT_W'(CAP_DEPTH));
  assign pop_ok      = cap_pop && (cap_cnt != '0);
  // A full buffer still takes a push when the oldest entry leaves in the same cycle
  assign push_ok     = mismatch && (!cap_full || pop_ok);
  assign cap_valid   = (cap_cnt != '0);
  assign cap_address = cap_addr_mem[cap_rp];
  assign cap_data    = cap_data_mem[cap_rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      pat          <= '0;
      fl_cnt       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      error_count  <= '0;
      cap_overflow <= 1'b0;
      cap_wp       <= '0;
      cap_rp       <= '0;
      cap_cnt      <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_addr[i] <= '0;
      end
      for (int unsigned i = 0; i < CAP_DEPTH; i++) begin
        cap_addr_mem[i] <= '0;
        cap_data_mem[i] <= '0;
      end
    end else begin
      // Read pipeline: address issued now is compared RD_LAT cycles later
      pipe_vld[0]  <= (state == S_READ);
      pipe_addr[0] <= mapped;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= write_mode ? S_WRITE : S_READ;
            pat   <= pattern;
            idx   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else if (state == S_DONE) begin
            done <= 1'b1;
          end
        end
        S_WRITE: begin
          idx <= idx + ADDR_W'(1);
          if (idx == '1) state <= S_READ;
        end
        S_READ: begin
          idx <= idx + ADDR_W'(1);
          if (idx == '1) begin
            state  <= S_FLUSH;
            fl_cnt <= '0;
          end
        end
        S_FLUSH: begin
          fl_cnt <= fl_cnt + FL_W'(1);
          if (fl_cnt == FL_W'(RD_LAT - 1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Error tracking and capture buffer; an accepted start wipes the previous test's results
      if (accept) begin
        error        <= 1'b0;
        error_count  <= '0;
        cap_overflow <= 1'b0;
        cap_wp       <= '0;
        cap_rp       <= '0;
        cap_cnt      <= '0;
      end else begin
        if (mismatch) begin
          error <= 1'b1;
          if (error_count != '1) error_count <= error_count + ERR_CNT_W'(1);
          if (!push_ok) cap_overflow <= 1'b1;
        end
        if (push_ok) begin
          cap_addr_mem[cap_wp] <= cmp_addr;
          cap_data_mem[cap_wp] <= ram_q;
          cap_wp               <= cap_wp + CAP_AW'(1);
        end
        if (pop_ok) cap_rp <= cap_rp + CAP_AW'(1);
        case ({push_ok, pop_ok})
          2'b10:   cap_cnt <= cap_cnt + CNT_W'(1);
          2'b01:   cap_cnt <= cap_cnt - CNT_W'(1);
          default: cap_cnt <= cap_cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_march_tester.sv
// Bench for ram_march_tester: directed vector table, reset sequences and randomized runs
// against a pass-level reference model; a second instance checks error counter saturation.
module tb_ram_march_tester;
  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned LAT = 2;
  localparam int unsigned N   = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic          write_mode;
  logic [DW-1:0] pattern;
  logic [AW-1:0] ram_address;
  logic          ram_wren;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;
  logic          busy;
  logic          done;
  logic          error;
  logic [15:0]   error_count;
  logic          cap_valid;
  logic [AW-1:0] cap_address;
  logic [DW-1:0] cap_data;
  logic          cap_pop;
  logic          cap_overflow;

  logic [AW-1:0] ram_address2;
  logic          ram_wren2;
  logic [DW-1:0] ram_data2;
  logic          busy2;
  logic          done2;
  logic          error2;
  logic [1:0]    error_count2;
  logic          cap_valid2;
  logic [AW-1:0] cap_address2;
  logic [DW-1:0] cap_data2;
  logic          cap_overflow2;

  ram_march_tester #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .CAP_DEPTH(4), .ERR_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .write_mode(write_mode), .pattern(pattern),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q),
    .busy(busy), .done(done), .error(error), .error_count(error_count),
    .cap_valid(cap_valid), .cap_address(cap_address), .cap_data(cap_data),
    .cap_pop(cap_pop), .cap_overflow(cap_overflow)
  );

  ram_march_tester #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .CAP_DEPTH(4), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .write_mode(write_mode), .pattern(pattern),
    .ram_address(ram_address2), .ram_wren(ram_wren2), .ram_data(ram_data2), .ram_q(ram_q),
    .busy(busy2), .done(done2), .error(error2), .error_count(error_count2),
    .cap_valid(cap_valid2), .cap_address(cap_address2), .cap_data(cap_data2),
    .cap_pop(cap_pop), .cap_overflow(cap_overflow2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: RD_LAT=2 read latency, optional per-address read corruption, bulk preload
  logic [DW-1:0] mem      [N];
  logic [DW-1:0] preload  [N];
  logic          corr_en  [N];
  logic [DW-1:0] corr_val [N];
  logic          do_load;
  logic [DW-1:0] rq1, rq2;

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < N; i++) mem[i] <= preload[i];
    end else if (ram_wren) begin
      mem[ram_address] <= ram_data;
    end
    rq1 <= corr_en[ram_address] ? corr_val[ram_address] : mem[ram_address];
    rq2 <= rq1;
  end
  assign ram_q = rq2;

  logic [AW+DW-1:0] wr_q [$];
  always @(negedge clk) if (ram_wren) wr_q.push_back({ram_address, ram_data});

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  function automatic logic [AW-1:0] map_idx(input int i);
    logic [AW-1:0] v;
    v = AW'(i);
`ifdef ADDR_SCRAMBLE_EN
    return {v[0], v[AW-1:1]};
`else
    return v;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a, input logic [DW-1:0] p);
    return a[0] ? ~p : p;
  endfunction

  logic [AW-1:0] cap_a_q [$];
  logic [DW-1:0] cap_d_q [$];

  // Reference: RAM content after the optional write pass, read back in map order
  task automatic model(input logic wm, input logic [DW-1:0] pat, output int nmis);
    logic [AW-1:0] a;
    logic [DW-1:0] want, stored, seen;
    cap_a_q.delete();
    cap_d_q.delete();
    nmis = 0;
    for (int i = 0; i < N; i++) begin
      a      = map_idx(i);
      want   = exp_word(a, pat);
      stored = wm ? want : preload[a];
      seen   = corr_en[a] ? corr_val[a] : stored;
      if (seen !== want) begin
        nmis++;
        if (cap_a_q.size() < 4) begin
          cap_a_q.push_back(a);
          cap_d_q.push_back(seen);
        end
      end
    end
  endtask

  task automatic reset_check(input string tag);
    chk({tag, ".wren"}, ram_wren, 0);
    chk({tag, ".addr"}, ram_address, 0);
    chk({tag, ".data"}, ram_data, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".error"}, error, 0);
    chk({tag, ".count"}, error_count, 0);
    chk({tag, ".cap_valid"}, cap_valid, 0);
    chk({tag, ".overflow"}, cap_overflow, 0);
    chk({tag, ".dut2"}, {ram_wren2, ram_address2, ram_data2, busy2, done2, error2,
                         error_count2, cap_valid2, cap_overflow2}, 0);
  endtask

  // Load RAM, start a test and wait (bounded) for done; lat = cycles from accepting edge to done
  task automatic run_test(input logic wm, input logic [DW-1:0] pat, input bit pulse_in_read,
                          output int lat);
    wr_q.delete();
    do_load = 1'b1;
    @(negedge clk);
    do_load    = 1'b0;
    start      = 1'b1;
    write_mode = wm;
    pattern    = pat;
    @(negedge clk);
    start      = 1'b0;
    write_mode = ~wm;
    pattern    = ~pat;
    lat        = 0;
    chk("start.busy", busy, 1);
    chk("start.done_cleared", done, 0);
    while (!done && lat < 300) begin
      start = pulse_in_read && (lat == (wm ? N : 0) + 3);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_results(input string tag, input logic wm, input logic [DW-1:0] pat,
                               input int lat, input logic exp_err, input logic [15:0] exp_cnt,
                               input logic [1:0] exp_cnt2, input logic exp_ovf);
    bit ok;
    chk({tag, ".latency"}, lat, (wm ? 2 * N : N) + LAT + 1);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".error"}, error, exp_err);
    chk({tag, ".count"}, error_count, exp_cnt);
    chk({tag, ".count_sat"}, error_count2, exp_cnt2);
    chk({tag, ".overflow"}, cap_overflow, exp_ovf);
    chk({tag, ".dut2_flags"}, {done2, error2, cap_overflow2}, {1'b1, exp_err, exp_ovf});
    if (wm) begin
      ok = (wr_q.size() == N);
      for (int i = 0; i < N && ok; i++)
        if (wr_q[i] !== {map_idx(i), exp_word(map_idx(i), pat)}) ok = 0;
      chk({tag, ".write_trace"}, ok, 1);
    end
    for (int k = 0; k < cap_a_q.size(); k++) begin
      chk({tag, ".cap_valid"}, cap_valid, 1);
      chk({tag, ".cap_address"}, cap_address, cap_a_q[k]);
      chk({tag, ".cap_data"}, cap_data, cap_d_q[k]);
      chk({tag, ".dut2_cap"}, {cap_valid2, cap_address2, cap_data2}, {1'b1, cap_a_q[k], cap_d_q[k]});
      cap_pop = 1'b1;
      @(negedge clk);
      cap_pop = 1'b0;
    end
    chk({tag, ".cap_empty"}, cap_valid, 0);
    cap_pop = 1'b1;
    @(negedge clk);
    cap_pop = 1'b0;
    chk({tag, ".pop_empty_ignored"}, {cap_valid, cap_valid2, done}, 3'b001);
  endtask

  typedef struct {
    logic          wm;
    logic [DW-1:0] pat;
    logic [DW-1:0] preload;
    logic [15:0]   corr_mask;
    logic [DW-1:0] corr_val;
    logic          exp_err;
    logic [15:0]   exp_cnt;
    logic [1:0]    exp_cnt2;
    int            exp_ncap;
    logic [15:0]   exp_caps;
    logic [DW-1:0] exp_cdata;
    logic          exp_ovf;
  } vec_t;

`ifdef ADDR_SCRAMBLE_EN
  localparam logic [15:0] CAPS_V3 = {4'd10, 4'd2, 4'd8, 4'd0};
  localparam logic [15:0] CAPS_V4 = {4'd4, 4'd3, 4'd9, 4'd1};
  localparam logic [15:0] CAPS_V5 = {4'd9, 4'd1, 4'd8, 4'd0};
`else
  localparam logic [15:0] CAPS_V3 = {4'd6, 4'd4, 4'd2, 4'd0};
  localparam logic [15:0] CAPS_V4 = {4'd7, 4'd4, 4'd3, 4'd1};
  localparam logic [15:0] CAPS_V5 = {4'd3, 4'd2, 4'd1, 4'd0};
`endif

  vec_t vecs [5];

  task automatic apply_vec(input vec_t v);
    for (int i = 0; i < N; i++) begin
      preload[i]  = v.preload;
      corr_en[i]  = v.corr_mask[i];
      corr_val[i] = v.corr_val;
    end
    cap_a_q.delete();
    cap_d_q.delete();
    for (int k = 0; k < v.exp_ncap; k++) begin
      cap_a_q.push_back(v.exp_caps[k*4 +: 4]);
      cap_d_q.push_back(v.exp_cdata);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat;
    int            nmis;
    int            n_wr;
    logic          wm;
    logic [DW-1:0] pat;

    reset = 1'b1; start = 1'b0; write_mode = 1'b0; pattern = '0; cap_pop = 1'b0; do_load = 1'b0;
    for (int i = 0; i < N; i++) begin
      preload[i] = '0; corr_en[i] = 1'b0; corr_val[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset_check("por");
    reset = 1'b0;
    @(negedge clk);

    // wm, pat, preload, corr_mask, corr_val, err, cnt, cnt_sat, ncap, caps, cap_data, ovf
    vecs[0] = '{1'b1, 8'hAA, 8'h00, 16'h0000, 8'h00, 1'b0, 16'd0,  2'd0, 0, 16'h0000, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 8'hAA, 8'h00, 16'h0020, 8'h00, 1'b1, 16'd1,  2'd1, 1, 16'h0005, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 8'hAA, 8'h55, 16'h0000, 8'h00, 1'b1, 16'd8,  2'd3, 4, CAPS_V3,  8'h55, 1'b1};
    vecs[3] = '{1'b1, 8'hAA, 8'h00, 16'h129A, 8'h00, 1'b1, 16'd6,  2'd3, 4, CAPS_V4,  8'h00, 1'b1};
    vecs[4] = '{1'b0, 8'hAA, 8'hFF, 16'h0000, 8'h00, 1'b1, 16'd16, 2'd3, 4, CAPS_V5,  8'hFF, 1'b1};

    for (int v = 0; v < 5; v++) begin
      apply_vec(vecs[v]);
      run_test(vecs[v].wm, vecs[v].pat, 1'b0, lat);
      check_results($sformatf("vec%0d", v), vecs[v].wm, vecs[v].pat, lat, vecs[v].exp_err,
                    vecs[v].exp_cnt, vecs[v].exp_cnt2, vecs[v].exp_ovf);
    end

    // Reset in DONE with sticky flags and captures outstanding
    apply_vec(vecs[3]);
    run_test(1'b1, 8'hAA, 1'b0, lat);
    chk("pre_reset.flags", {error, cap_valid, cap_overflow, done}, 4'b1111);
    reset = 1'b1;
    @(negedge clk);
    reset_check("rst_done");
    reset = 1'b0;

    // Reset in cycle 10 of the write pass: no further writes, then a clean full test
    apply_vec(vecs[0]);
    wr_q.delete();
    do_load = 1'b1;
    @(negedge clk);
    do_load = 1'b0; start = 1'b1; write_mode = 1'b1; pattern = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset_check("rst_mid");
    reset = 1'b0;
    n_wr = wr_q.size();
    chk("rst_mid.writes_before", n_wr, 11);
    repeat (20) @(negedge clk);
    chk("rst_mid.writes_after", wr_q.size(), n_wr);
    chk("rst_mid.idle", {busy, done, ram_wren}, 3'b000);
    run_test(1'b1, 8'hAA, 1'b1, lat);
    check_results("after_rst", 1'b1, 8'hAA, lat, 1'b0, 16'd0, 2'd0, 1'b0);

    // Randomized runs against the pass-level model
    for (int r = 0; r < 24; r++) begin
      wm  = 1'($urandom_range(1));
      pat = 8'($urandom);
      for (int i = 0; i < N; i++) begin
        preload[i]  = 8'($urandom);
        corr_en[i]  = ($urandom_range(3) == 0);
        corr_val[i] = 8'($urandom);
      end
      model(wm, pat, nmis);
      run_test(wm, pat, 1'($urandom_range(1)), lat);
      check_results($sformatf("rand%0d", r), wm, pat, lat, nmis > 0, 16'(nmis),
                    (nmis > 3) ? 2'd3 : 2'(nmis), nmis > 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
